iomem_fetch: RTL and testbench

Bus-initiator block that reads a contiguous run of 32-bit words over the picosoc `iomem_*` valid/ready interface and buffers them in an internal FIFO for a streaming consumer such as the VGA pixel pipeline. It is the initiator counterpart to the existing `iomem` responders such as the GPIO register. Its `iomem_*` outputs feed an address-decoded responder, or an arbiter in front of one, on the `clk` domain.

---
 rtl/iomem_pkg.sv | 14 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/iomem_fetch.sv | 135 +++++++++++++
 tb/tb_iomem_fetch.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for iomem initiators: fetch FSM states and read-only bus constants.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_SPACE,
    ST_FINISH
  } fetch_state_e;

  localparam logic [3:0] IOMEM_WSTRB_READ = 4'b0000;
  localparam int         IOMEM_WORD_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
  assign do_push = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/iomem_fetch.sv
// Reads LINE_WORDS consecutive words over the iomem bus into a FIFO for a streaming consumer.
// Optional watchdog abort is enabled by defining IOMEM_FETCH_TIMEOUT_EN.
module iomem_fetch
  import iomem_pkg::*;
#(
  parameter int LINE_WORDS     = 160,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        rd_en
);

  localparam int CNT_W = $clog2(LINE_WORDS + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [LVL_W-1:0] fifo_count;
  logic             fifo_has_space;
  logic             accept;
  logic             timeout_hit;

  assign fifo_has_space = fifo_count < LVL_W'(FIFO_DEPTH);
  assign accept         = (state_q == ST_REQ) && iomem_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (iomem_rdata),
    .pop   (rd_en),
    .rdata (rd_data),
    .count (fifo_count)
  );

`ifdef IOMEM_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            error_q;

  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ST_REQ) && !iomem_ready) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == ST_REQ) && !iomem_ready &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= timeout_hit;
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // WAIT_SPACE doubles as the mandatory one-cycle valid gap after every accept.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr & ~32'h3;
          word_cnt_d = '0;
          state_d    = fifo_has_space ? ST_REQ : ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (fifo_has_space) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (iomem_ready) begin
          addr_d     = addr_q + 32'(IOMEM_WORD_BYTES);
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = (word_cnt_q == CNT_W'(LINE_WORDS - 1)) ? ST_FINISH : ST_WAIT_SPACE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign iomem_valid = (state_q == ST_REQ);
  assign iomem_addr  = addr_q;
  assign iomem_wstrb = IOMEM_WSTRB_READ;
  assign iomem_wdata = 32'h0;
  assign busy        = (state_q == ST_REQ) || (state_q == ST_WAIT_SPACE);
  assign done        = (state_q == ST_FINISH);
  assign rd_valid    = (fifo_count != '0);

endmodule

// File: tb/tb_iomem_fetch.sv
// Self-checking bench for iomem_fetch: randomized lines against an address/data reference model.
module tb_iomem_fetch;

  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 10;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, error, iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata;
  logic [31:0] iomem_rdata = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_en = 1'b0;

  iomem_fetch #(.LINE_WORDS(LW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_en(rd_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // responder / protocol monitor state
  int          ready_delay = 1;
  logic        silent = 1'b0;
  logic        force_ready = 1'b0;
  int          wait_cnt = 0;
  int          stall_cnt = 0;
  int          gap_bad = 0, stab_bad = 0, wstrb_bad = 0;
  logic        gap_expect = 1'b0, hold_expect = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] acc_addr_q[$];
  logic [31:0] popped_q[$];

  // run_line results
  int          done_at, done_n;
  logic        first_valid;
  logic [31:0] first_addr;
  logic        busy_at_done;

  function automatic logic [31:0] model_addr(input logic [31:0] base, input int i);
    logic [31:0] b;
    b = base;
    b[1:0] = 2'b00;
    return b + 32'(4 * i);
  endfunction

  // Responder drives ready/rdata at the falling edge; records every accept it grants.
  always @(negedge clk) begin
    if (iomem_wstrb !== 4'b0000 || iomem_wdata !== 32'h0) wstrb_bad++;
    if (gap_expect && iomem_valid) gap_bad++;
    if (hold_expect && iomem_valid && iomem_addr !== hold_addr) stab_bad++;
    gap_expect  = 1'b0;
    hold_expect = 1'b0;
    iomem_ready = 1'b0;
    if (force_ready) begin
      iomem_ready = 1'b1;
      iomem_rdata = 32'hDEADBEEF;
    end else if (iomem_valid && !silent) begin
      if (wait_cnt >= ready_delay) begin
        iomem_ready = 1'b1;
        iomem_rdata = iomem_addr ^ PAT;
        wait_cnt = 0;
        if (!reset) begin
          acc_addr_q.push_back(iomem_addr);
          gap_expect = 1'b1;
        end
      end else begin
        wait_cnt++;
        hold_expect = 1'b1;
        hold_addr = iomem_addr;
        stall_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_logs();
    acc_addr_q.delete();
    popped_q.delete();
    stall_cnt = 0;
  endtask

  // Starts a line and services the FIFO until done has been seen and the FIFO is drained.
  task automatic run_line(input logic [31:0] base, input int pop_pct);
    done_at = -1;
    done_n = 0;
    busy_at_done = 1'b1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    first_valid = iomem_valid;
    first_addr = iomem_addr;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = cyc;
          busy_at_done = busy;
        end
      end
      if (done_at >= 0 && !rd_valid && cyc > done_at) begin
        rd_en = 1'b0;
        break;
      end
      if (rd_valid && $urandom_range(99) < pop_pct) begin
        popped_q.push_back(rd_data);
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
  endtask

  task automatic check_line_contents(input string tag, input logic [31:0] base);
    n_cmp++;
    if (acc_addr_q.size() != LW || popped_q.size() != LW) begin
      n_mis++;
      $display("FAIL %s_count: got %0d accepts / %0d pops, need %0d", tag,
               acc_addr_q.size(), popped_q.size(), LW);
    end else begin
      $display("line %s: %0d words from base %08h", tag, LW, base);
    end
    for (int i = 0; i < LW && i < acc_addr_q.size(); i++) begin
      n_cmp++;
      if (acc_addr_q[i] !== model_addr(base, i)) begin
        n_mis++;
        $display("FAIL %s_addr[%0d]: got %08h need %08h", tag, i, acc_addr_q[i], model_addr(base, i));
      end
    end
    for (int i = 0; i < LW && i < popped_q.size(); i++) begin
      n_cmp++;
      if (popped_q[i] !== (model_addr(base, i) ^ PAT)) begin
        n_mis++;
        $display("FAIL %s_data[%0d]: got %08h need %08h", tag, i, popped_q[i], model_addr(base, i) ^ PAT);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, error, iomem_valid, rd_valid} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got %05b need 00000", {busy, done, error, iomem_valid, rd_valid});
    end
    n_cmp++;
    if (iomem_addr !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_addr: got %08h need 00000000", iomem_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || iomem_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_after_reset: busy=%b valid=%b need 0 0", busy, iomem_valid);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_basic_line();
    logic [31:0] base;
    base = $urandom();
    ready_delay = 1;
    clear_logs();
    gap_bad = 0; stab_bad = 0; wstrb_bad = 0;
    run_line(base, 100);
    n_cmp++;
    if (first_valid !== 1'b1 || first_addr !== model_addr(base, 0)) begin
      n_mis++;
      $display("FAIL basic_first_req: valid=%b addr=%08h need 1 %08h", first_valid, first_addr, model_addr(base, 0));
    end
    n_cmp++;
    if (done_n != 1 || done_at != 3 * LW - 1) begin
      n_mis++;
      $display("FAIL basic_done: %0d pulses at cycle %0d, need 1 at %0d", done_n, done_at, 3 * LW - 1);
    end
    n_cmp++;
    if (busy_at_done !== 1'b0) begin
      n_mis++;
      $display("FAIL basic_busy_at_done: got %b need 0", busy_at_done);
    end
    n_cmp++;
    if (gap_bad != 0 || wstrb_bad != 0) begin
      n_mis++;
      $display("FAIL basic_protocol: gap_violations=%0d wstrb_violations=%0d need 0 0", gap_bad, wstrb_bad);
    end
    check_line_contents("basic", base);
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    logic [31:0] head;
    int          dn;
    base = $urandom() & 32'h00FF_FFF0;
    ready_delay = 1;
    clear_logs();
    rd_en = 1'b0;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (acc_addr_q.size() != DEPTH || iomem_valid !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_full: accepts=%0d valid=%b busy=%b need %0d 0 1", acc_addr_q.size(), iomem_valid, busy, DEPTH);
    end
    head = rd_data;
    popped_q.push_back(head);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (acc_addr_q.size() != DEPTH + 1 || iomem_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_one_more: accepts=%0d valid=%b need %0d 0", acc_addr_q.size(), iomem_valid, DEPTH + 1);
    end
    dn = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) dn++;
      if (popped_q.size() == LW && !busy) break;
      if (rd_valid) begin
        popped_q.push_back(rd_data);
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_cmp++;
    if (dn != 1 || rd_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_drain: done_pulses=%0d rd_valid=%b need 1 0", dn, rd_valid);
    end
    check_line_contents("backpressure", base);
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    base = 32'hFFFFFFF6;
    ready_delay = $urandom_range(0, 2);
    clear_logs();
    run_line(base, 40);
    n_cmp++;
    if (done_n != 1) begin
      n_mis++;
      $display("FAIL wrap_done: got %0d pulses need 1", done_n);
    end
    check_line_contents("wrap", base);
    ready_delay = 1;
  endtask

  task automatic test_stall_protocol();
    logic [31:0] base;
    int          dn;
    int          busy_drop;
    base = $urandom() & 32'h7FFF_FFFC;
    ready_delay = 7;
    clear_logs();
    gap_bad = 0; stab_bad = 0;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    busy_drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 20) begin
        start = 1'b1;
        base_addr = base ^ 32'h8000_0000;
      end else begin
        start = 1'b0;
      end
      if (done) dn++;
      if (!busy && !done && dn == 0) busy_drop++;
      if (rd_valid) begin
        popped_q.push_back(rd_data);
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      if (dn > 0 && !rd_valid) break;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (stab_bad != 0 || gap_bad != 0) begin
      n_mis++;
      $display("FAIL stall_protocol: unstable=%0d gap_violations=%0d need 0 0", stab_bad, gap_bad);
    end
    n_cmp++;
    if (stall_cnt != 7 * LW) begin
      n_mis++;
      $display("FAIL stall_cycles: got %0d held cycles need %0d", stall_cnt, 7 * LW);
    end
    n_cmp++;
    if (dn != 1 || busy_drop != 0) begin
      n_mis++;
      $display("FAIL stall_busy: done_pulses=%0d early_busy_low=%0d need 1 0", dn, busy_drop);
    end
    check_line_contents("stall", base);
    ready_delay = 1;
  endtask

  task automatic test_reset_midline();
    logic [31:0] b1, b2;
    int          found;
    b1 = $urandom() & 32'hFFFF_0FFC;
    b2 = $urandom() | 32'h0000_F000;
    ready_delay = 1;
    clear_logs();
    rd_en = 1'b0;
    start = 1'b1;
    base_addr = b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (acc_addr_q.size() == 2 && iomem_valid) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (found == 0) begin
      n_mis++;
      $display("FAIL midline_setup: third request never seen (accepts=%0d)", acc_addr_q.size());
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    force_ready = 1'b1;
    n_cmp++;
    if ({busy, done, error, iomem_valid, rd_valid} !== 5'b0 || iomem_addr !== 32'h0) begin
      n_mis++;
      $display("FAIL midline_reset: flags=%05b addr=%08h need 00000 00000000",
               {busy, done, error, iomem_valid, rd_valid}, iomem_addr);
    end
    @(posedge clk); #1;
    force_ready = 1'b0;
    n_cmp++;
    if (iomem_valid !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL late_ready: valid=%b busy=%b rd_valid=%b need 0 0 0", iomem_valid, busy, rd_valid);
    end
    clear_logs();
    run_line(b2, 100);
    n_cmp++;
    if (done_n != 1) begin
      n_mis++;
      $display("FAIL refetch_done: got %0d pulses need 1", done_n);
    end
    check_line_contents("refetch", b2);
  endtask

  task automatic test_timeout();
    silent = 1'b1;
    clear_logs();
    start = 1'b1;
    base_addr = $urandom();
    @(posedge clk); #1;
    start = 1'b0;
`ifdef IOMEM_FETCH_TIMEOUT_EN
    repeat (TO - 1) @(posedge clk);
    #1;
    n_cmp++;
    if (error !== 1'b0 || iomem_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL timeout_early: error=%b valid=%b need 0 1", error, iomem_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({error, busy, iomem_valid, done} !== 4'b1000) begin
      n_mis++;
      $display("FAIL timeout_abort: err/busy/valid/done=%04b need 1000", {error, busy, iomem_valid, done});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (error !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL timeout_pulse: error=%b done=%b need 0 0", error, done);
    end
    $display("timeout: abort after %0d cycles", TO);
    silent = 1'b0;
`else
    repeat (3 * TO) @(posedge clk);
    #1;
    n_cmp++;
    if (iomem_valid !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      n_mis++;
      $display("FAIL no_timeout: valid=%b busy=%b error=%b need 1 1 0", iomem_valid, busy, error);
    end
    $display("timeout: disabled, request still pending");
    silent = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_backpressure();
    test_wrap();
    test_stall_protocol();
    test_reset_midline();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
